// File: rtl/dbg_multihart_ctrl.sv
// Debug-side multi-hart controller: routes halt/resume to a selected hart set,
// summarises per-hart status and sequences one abstract register access at a time.
module dbg_multihart_ctrl #(
  parameter int unsigned NUM_HARTS  = 2,
  parameter int unsigned HARTSEL_W  = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned AR_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [HARTSEL_W-1:0]        dm_hartsel,
  input  logic                        dm_hasel,
  input  logic [NUM_HARTS-1:0]        dm_hamask,
  input  logic                        dm_haltreq,
  input  logic                        dm_resumereq,
  input  logic                        dm_ar_valid,
  output logic                        dm_ar_ready,
  input  logic                        dm_ar_wr,
  input  logic [15:0]                 dm_ar_ad,
  input  logic [DATA_W-1:0]           dm_ar_wdata,
  output logic                        dm_ar_rvalid,
  output logic [DATA_W-1:0]           dm_ar_rdata,
  output logic [2:0]                  dm_ar_cmderr,
  output logic                        dm_anyhalted,
  output logic                        dm_allhalted,
  output logic                        dm_anyrunning,
  output logic                        dm_allrunning,
  output logic                        dm_anyresumeack,
  output logic                        dm_allresumeack,
  output logic                        dm_anynonexistent,
  output logic [NUM_HARTS-1:0]        core_haltreq,
  output logic [NUM_HARTS-1:0]        core_resumereq,
  input  logic [NUM_HARTS-1:0]        core_halted,
  input  logic [NUM_HARTS-1:0]        core_running,
  input  logic [NUM_HARTS-1:0]        core_resumeack,
  output logic [NUM_HARTS-1:0]        core_ar_en,
  output logic                        core_ar_wr,
  output logic [15:0]                 core_ar_ad,
  output logic [DATA_W-1:0]           core_ar_do,
  input  logic [NUM_HARTS*DATA_W-1:0] core_ar_di,
  input  logic [NUM_HARTS-1:0]        core_ar_done
);

  localparam int unsigned       CNT_W    = $clog2(AR_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(AR_TIMEOUT - 1);
  localparam logic [15:0]       AD_UNSUP = 16'h1020;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t               state, state_n;
  logic [NUM_HARTS-1:0] hart_onehot, sel;
  logic [NUM_HARTS-1:0] pending, ack, ack_evt, arm, clr;
  logic                 resume_q, resume_edge;
  logic [NUM_HARTS-1:0] tgt;
  logic [CNT_W-1:0]     cnt;
  logic                 done_lat;
  logic [DATA_W-1:0]    di_lat, di_sel;
  logic                 tgt_done, tgt_halted;
  logic                 accept, resp_load;
  logic [2:0]           resp_err_n;
  logic [DATA_W-1:0]    resp_data_n;

  // A hartsel beyond NUM_HARTS yields an all-zero one-hot, which doubles as the nonexistent flag.
  always_comb begin
    hart_onehot = '0;
    for (int unsigned i = 0; i < NUM_HARTS; i++)
      if (dm_hartsel == HARTSEL_W'(i)) hart_onehot[i] = 1'b1;
    sel = hart_onehot | (dm_hasel ? dm_hamask : '0);
  end

  assign dm_anynonexistent = ~|hart_onehot;
  assign dm_anyhalted      = |(core_halted & sel);
  assign dm_allhalted      = (sel != '0) && ((core_halted & sel) == sel);
  assign dm_anyrunning     = |(core_running & sel);
  assign dm_allrunning     = (sel != '0) && ((core_running & sel) == sel);
  assign dm_anyresumeack   = |(ack & sel);
  assign dm_allresumeack   = (sel != '0) && ((ack & sel) == sel);

  // Resume: an edge always clears acks of the selection, but arms only halted harts and only when no halt is requested.
  assign resume_edge    = dm_resumereq & ~resume_q;
  assign ack_evt        = pending & core_resumeack;
  assign arm            = (resume_edge && !dm_haltreq) ? (sel & core_halted) : '0;
  assign clr            = resume_edge ? sel : '0;
  assign core_resumereq = pending & ~{NUM_HARTS{dm_haltreq}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resume_q     <= 1'b0;
      pending      <= '0;
      ack          <= '0;
      core_haltreq <= '0;
    end else begin
      resume_q     <= dm_resumereq;
      pending      <= (pending & ~ack_evt) | arm;
      ack          <= (ack & ~clr) | ack_evt;
      core_haltreq <= {NUM_HARTS{dm_haltreq}} & sel;
    end
  end

  always_comb begin
    di_sel = '0;
    for (int unsigned i = 0; i < NUM_HARTS; i++)
      if (tgt[i]) di_sel = di_sel | core_ar_di[i*DATA_W +: DATA_W];
  end

  assign tgt_done     = |(core_ar_done & tgt);
  assign tgt_halted   = |(core_halted & tgt);
  assign dm_ar_ready  = (state == ST_IDLE);
  assign dm_ar_rvalid = (state == ST_RESP);
  assign core_ar_en   = (state == ST_ISSUE || state == ST_WAIT) ? tgt : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    resp_load   = 1'b0;
    resp_err_n  = 3'd0;
    resp_data_n = '0;
    case (state)
      ST_IDLE: begin
        if (dm_ar_valid) begin
          accept    = 1'b1;
          state_n   = ST_RESP;
          resp_load = 1'b1;
          if (~|hart_onehot)                    resp_err_n = 3'd7;
          else if (~|(core_halted & hart_onehot)) resp_err_n = 3'd4;
          else if (dm_ar_ad >= AD_UNSUP)         resp_err_n = 3'd2;
          else begin
            state_n   = ST_ISSUE;
            resp_load = 1'b0;
          end
        end
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        if (done_lat || tgt_done) begin
          state_n     = ST_RESP;
          resp_load   = 1'b1;
          resp_data_n = core_ar_wr ? '0 : (done_lat ? di_lat : di_sel);
        end else if (!tgt_halted) begin
          state_n    = ST_RESP;
          resp_load  = 1'b1;
          resp_err_n = 3'd4;
        end else if (cnt == CNT_LAST) begin
          state_n    = ST_RESP;
          resp_load  = 1'b1;
          resp_err_n = 3'd7;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // A done seen while in ISSUE is captured together with its data so WAIT can complete on it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt          <= '0;
      core_ar_wr   <= 1'b0;
      core_ar_ad   <= '0;
      core_ar_do   <= '0;
      cnt          <= '0;
      done_lat     <= 1'b0;
      di_lat       <= '0;
      dm_ar_rdata  <= '0;
      dm_ar_cmderr <= 3'd0;
    end else begin
      if (accept) begin
        tgt        <= hart_onehot;
        core_ar_wr <= dm_ar_wr;
        core_ar_ad <= dm_ar_ad;
        core_ar_do <= dm_ar_wdata;
      end
      if (state == ST_ISSUE) begin
        cnt      <= '0;
        done_lat <= tgt_done;
        di_lat   <= di_sel;
      end else if (state == ST_WAIT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (resp_load) begin
        dm_ar_rdata  <= resp_data_n;
        dm_ar_cmderr <= resp_err_n;
      end
    end
  end

endmodule

// File: tb/tb_dbg_multihart_ctrl.sv
// Directed bench for dbg_multihart_ctrl: halt/resume routing, status aggregation
// and the abstract-access sequencer including errors, timeout and async reset.
module tb_dbg_multihart_ctrl;

  localparam int unsigned NH  = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    dm_hartsel;
  logic          dm_hasel;
  logic [NH-1:0] dm_hamask;
  logic          dm_haltreq, dm_resumereq;
  logic          dm_ar_valid, dm_ar_ready, dm_ar_wr;
  logic [15:0]   dm_ar_ad;
  logic [DW-1:0] dm_ar_wdata, dm_ar_rdata;
  logic          dm_ar_rvalid;
  logic [2:0]    dm_ar_cmderr;
  logic          dm_anyhalted, dm_allhalted, dm_anyrunning, dm_allrunning;
  logic          dm_anyresumeack, dm_allresumeack, dm_anynonexistent;
  logic [NH-1:0] core_haltreq, core_resumereq, core_halted, core_running, core_resumeack;
  logic [NH-1:0] core_ar_en, core_ar_done;
  logic          core_ar_wr;
  logic [15:0]   core_ar_ad;
  logic [DW-1:0] core_ar_do;
  logic [NH*DW-1:0] core_ar_di;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbg_multihart_ctrl #(.NUM_HARTS(NH), .HARTSEL_W(4), .DATA_W(DW), .AR_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .dm_hartsel(dm_hartsel), .dm_hasel(dm_hasel), .dm_hamask(dm_hamask),
    .dm_haltreq(dm_haltreq), .dm_resumereq(dm_resumereq),
    .dm_ar_valid(dm_ar_valid), .dm_ar_ready(dm_ar_ready), .dm_ar_wr(dm_ar_wr),
    .dm_ar_ad(dm_ar_ad), .dm_ar_wdata(dm_ar_wdata), .dm_ar_rvalid(dm_ar_rvalid),
    .dm_ar_rdata(dm_ar_rdata), .dm_ar_cmderr(dm_ar_cmderr),
    .dm_anyhalted(dm_anyhalted), .dm_allhalted(dm_allhalted),
    .dm_anyrunning(dm_anyrunning), .dm_allrunning(dm_allrunning),
    .dm_anyresumeack(dm_anyresumeack), .dm_allresumeack(dm_allresumeack),
    .dm_anynonexistent(dm_anynonexistent),
    .core_haltreq(core_haltreq), .core_resumereq(core_resumereq),
    .core_halted(core_halted), .core_running(core_running), .core_resumeack(core_resumeack),
    .core_ar_en(core_ar_en), .core_ar_wr(core_ar_wr), .core_ar_ad(core_ar_ad),
    .core_ar_do(core_ar_do), .core_ar_di(core_ar_di), .core_ar_done(core_ar_done)
  );

  task automatic test_reset();
    reset_n = 1'b0; dm_hartsel = '0; dm_hasel = 1'b0; dm_hamask = '0;
    dm_haltreq = 1'b0; dm_resumereq = 1'b0; dm_ar_valid = 1'b0; dm_ar_wr = 1'b0;
    dm_ar_ad = '0; dm_ar_wdata = '0; core_halted = '0; core_running = '0;
    core_resumeack = '0; core_ar_done = '0; core_ar_di = '0;
    #13;
    checks++; if (dm_ar_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", dm_ar_ready); end
    checks++; if (dm_ar_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b exp 0", dm_ar_rvalid); end
    checks++; if (core_haltreq !== 2'b00 || core_resumereq !== 2'b00) begin errors++; $display("FAIL reset_core_req got %b/%b exp 00/00", core_haltreq, core_resumereq); end
    checks++; if (core_ar_en !== 2'b00) begin errors++; $display("FAIL reset_ar_en got %b exp 00", core_ar_en); end
    checks++; if (dm_ar_cmderr !== 3'd0 || dm_ar_rdata !== '0) begin errors++; $display("FAIL reset_resp got %0d/%h exp 0/0", dm_ar_cmderr, dm_ar_rdata); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++; if (dm_ar_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b exp 1", dm_ar_ready); end
  endtask

  task automatic test_halt();
    dm_hartsel = 4'd1; dm_haltreq = 1'b1; core_running = 2'b01;
    #1;
    checks++; if (core_haltreq !== 2'b00) begin errors++; $display("FAIL halt_latency got %b exp 00", core_haltreq); end
    @(negedge clk);
    checks++; if (core_haltreq !== 2'b10) begin errors++; $display("FAIL halt_req got %b exp 10", core_haltreq); end
    core_halted = 2'b10; core_running = 2'b01; #1;
    checks++; if (dm_anyhalted !== 1'b1 || dm_allhalted !== 1'b1) begin errors++; $display("FAIL halt_status got any=%0b all=%0b exp 1/1", dm_anyhalted, dm_allhalted); end
    checks++; if (dm_anyrunning !== 1'b0 || dm_anynonexistent !== 1'b0) begin errors++; $display("FAIL halt_running got run=%0b nx=%0b exp 0/0", dm_anyrunning, dm_anynonexistent); end
    dm_hartsel = 4'd3; #1;
    checks++; if (dm_anynonexistent !== 1'b1) begin errors++; $display("FAIL nonexist got %0b exp 1", dm_anynonexistent); end
    checks++; if (dm_allhalted !== 1'b0 || dm_allrunning !== 1'b0 || dm_allresumeack !== 1'b0) begin errors++; $display("FAIL nonexist_all got %0b%0b%0b exp 000", dm_allhalted, dm_allrunning, dm_allresumeack); end
    @(negedge clk);
    checks++; if (core_haltreq !== 2'b00) begin errors++; $display("FAIL nonexist_haltreq got %b exp 00", core_haltreq); end
    dm_haltreq = 1'b0; dm_hartsel = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_resume();
    dm_hasel = 1'b1; dm_hamask = 2'b11; core_halted = 2'b11; core_running = 2'b00;
    @(negedge clk); dm_resumereq = 1'b1;
    @(negedge clk);
    checks++; if (core_resumereq !== 2'b11) begin errors++; $display("FAIL resume_req got %b exp 11", core_resumereq); end
    checks++; if (dm_anyresumeack !== 1'b0) begin errors++; $display("FAIL resume_ack0 got %0b exp 0", dm_anyresumeack); end
    core_resumeack = 2'b01;
    @(negedge clk);
    checks++; if (dm_anyresumeack !== 1'b1 || dm_allresumeack !== 1'b0) begin errors++; $display("FAIL resume_ack1 got any=%0b all=%0b exp 1/0", dm_anyresumeack, dm_allresumeack); end
    checks++; if (core_resumereq !== 2'b10) begin errors++; $display("FAIL resume_req1 got %b exp 10", core_resumereq); end
    core_resumeack = 2'b10; core_halted = 2'b10; core_running = 2'b01;
    @(negedge clk);
    checks++; if (dm_allresumeack !== 1'b1 || core_resumereq !== 2'b00) begin errors++; $display("FAIL resume_ack2 got all=%0b req=%b exp 1/00", dm_allresumeack, core_resumereq); end
    core_resumeack = 2'b00; dm_resumereq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_resume_halt_wins();
    core_halted = 2'b11; core_running = 2'b00; dm_haltreq = 1'b1;
    @(negedge clk); dm_resumereq = 1'b1;
    @(negedge clk);
    checks++; if (core_haltreq !== 2'b11) begin errors++; $display("FAIL hw_haltreq got %b exp 11", core_haltreq); end
    checks++; if (core_resumereq !== 2'b00 || dm_anyresumeack !== 1'b0) begin errors++; $display("FAIL hw_resume got req=%b ack=%0b exp 00/0", core_resumereq, dm_anyresumeack); end
    dm_haltreq = 1'b0; dm_resumereq = 1'b0; #1;
    checks++; if (core_resumereq !== 2'b00) begin errors++; $display("FAIL hw_not_armed got %b exp 00", core_resumereq); end
    @(negedge clk);
    core_halted = 2'b01; core_running = 2'b10; dm_resumereq = 1'b1;
    @(negedge clk);
    checks++; if (core_resumereq !== 2'b01) begin errors++; $display("FAIL running_ignored got %b exp 01", core_resumereq); end
    core_resumeack = 2'b11;
    @(negedge clk);
    checks++; if (dm_anyresumeack !== 1'b1 || dm_allresumeack !== 1'b0 || core_resumereq !== 2'b00) begin errors++; $display("FAIL running_ack got any=%0b all=%0b req=%b exp 1/0/00", dm_anyresumeack, dm_allresumeack, core_resumereq); end
    core_resumeack = 2'b00; dm_resumereq = 1'b0; dm_hasel = 1'b0; dm_hamask = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_ar_read();
    int en_cnt; bit got;
    dm_hartsel = 4'd0; core_halted = 2'b01; core_running = 2'b10;
    dm_ar_valid = 1'b1; dm_ar_wr = 1'b0; dm_ar_ad = 16'h1005; #1;
    checks++; if (dm_ar_ready !== 1'b1) begin errors++; $display("FAIL rd_ready got %0b exp 1", dm_ar_ready); end
    en_cnt = 0; got = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      dm_ar_valid = 1'b0;
      if (core_ar_en != 2'b00) en_cnt++;
      if (k == 1) begin
        checks++; if (core_ar_en !== 2'b01 || core_ar_ad !== 16'h1005 || core_ar_wr !== 1'b0) begin errors++; $display("FAIL rd_issue got en=%b ad=%h wr=%0b exp 01/1005/0", core_ar_en, core_ar_ad, core_ar_wr); end
      end
      if (dm_ar_rvalid) got = 1;
      else if (k == 3) begin core_ar_done = 2'b01; core_ar_di = {32'h0, 32'hDEADBEEF}; end
    end
    core_ar_done = 2'b00;
    checks++; if (!got || dm_ar_rdata !== 32'hDEADBEEF || dm_ar_cmderr !== 3'd0) begin errors++; $display("FAIL rd_resp got rv=%0b data=%h err=%0d exp 1/deadbeef/0", got, dm_ar_rdata, dm_ar_cmderr); end
    checks++; if (en_cnt != 3) begin errors++; $display("FAIL rd_en_cycles got %0d exp 3", en_cnt); end
    @(negedge clk);
    checks++; if (dm_ar_rvalid !== 1'b0 || dm_ar_ready !== 1'b1) begin errors++; $display("FAIL rd_pulse got rv=%0b rdy=%0b exp 0/1", dm_ar_rvalid, dm_ar_ready); end
  endtask

  task automatic test_ar_done_in_issue();
    dm_hartsel = 4'd1; core_halted = 2'b10; core_ar_di = {32'h12345678, 32'h0};
    dm_ar_valid = 1'b1; dm_ar_wr = 1'b1; dm_ar_ad = 16'h1001; dm_ar_wdata = 32'hCAFEF00D;
    @(negedge clk); dm_ar_valid = 1'b0;
    checks++; if (core_ar_en !== 2'b10 || core_ar_wr !== 1'b1 || core_ar_do !== 32'hCAFEF00D) begin errors++; $display("FAIL wr_issue got en=%b wr=%0b do=%h exp 10/1/cafef00d", core_ar_en, core_ar_wr, core_ar_do); end
    core_ar_done = 2'b10;
    @(negedge clk); core_ar_done = 2'b00;
    @(negedge clk);
    checks++; if (dm_ar_rvalid !== 1'b1 || dm_ar_cmderr !== 3'd0 || dm_ar_rdata !== 32'h0) begin errors++; $display("FAIL wr_latched_done got rv=%0b err=%0d data=%h exp 1/0/0", dm_ar_rvalid, dm_ar_cmderr, dm_ar_rdata); end
    @(negedge clk);
  endtask

  task automatic test_ar_errors();
    logic [3:0]  sel_t [4] = '{4'd1, 4'd0, 4'd0, 4'd3};
    logic [15:0] ad_t  [4] = '{16'h1000, 16'h2000, 16'h1020, 16'h1000};
    logic [2:0]  err_t [4] = '{3'd4, 3'd2, 3'd2, 3'd7};
    core_halted = 2'b01; core_running = 2'b10; dm_ar_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dm_hartsel = sel_t[i]; dm_ar_ad = ad_t[i]; dm_ar_valid = 1'b1;
      @(negedge clk); dm_ar_valid = 1'b0;
      checks++; if (dm_ar_rvalid !== 1'b1 || dm_ar_cmderr !== err_t[i] || core_ar_en !== 2'b00) begin errors++; $display("FAIL ar_err%0d got rv=%0b err=%0d en=%b exp 1/%0d/00", i, dm_ar_rvalid, dm_ar_cmderr, core_ar_en, err_t[i]); end
      @(negedge clk);
    end
    dm_hartsel = 4'd0; dm_ar_ad = 16'h1001; dm_ar_valid = 1'b1;
    @(negedge clk); dm_ar_valid = 1'b0;
    @(negedge clk); core_halted = 2'b00;
    @(negedge clk);
    checks++; if (dm_ar_rvalid !== 1'b1 || dm_ar_cmderr !== 3'd4) begin errors++; $display("FAIL ar_halt_drop got rv=%0b err=%0d exp 1/4", dm_ar_rvalid, dm_ar_cmderr); end
    core_halted = 2'b01;
    @(negedge clk);
  endtask

  task automatic test_timeout_and_reset();
    int en_cnt; bit got;
    dm_hartsel = 4'd0; dm_ar_ad = 16'h1000; dm_ar_valid = 1'b1;
    en_cnt = 0; got = 0;
    for (int k = 1; k <= 100 && !got; k++) begin
      @(negedge clk); dm_ar_valid = 1'b0;
      if (core_ar_en != 2'b00) en_cnt++;
      if (dm_ar_rvalid) got = 1;
    end
    checks++; if (!got || dm_ar_cmderr !== 3'd7) begin errors++; $display("FAIL timeout_resp got rv=%0b err=%0d exp 1/7", got, dm_ar_cmderr); end
    checks++; if (en_cnt != TMO + 1) begin errors++; $display("FAIL timeout_cycles got %0d exp %0d", en_cnt, TMO + 1); end
    @(negedge clk);
    dm_ar_valid = 1'b1;
    @(negedge clk); dm_ar_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (core_ar_en !== 2'b01 || dm_ar_ready !== 1'b0) begin errors++; $display("FAIL mid_wait got en=%b rdy=%0b exp 01/0", core_ar_en, dm_ar_ready); end
    #2 reset_n = 1'b0; #1;
    checks++; if (core_ar_en !== 2'b00 || dm_ar_ready !== 1'b1) begin errors++; $display("FAIL async_reset got en=%b rdy=%0b exp 00/1", core_ar_en, dm_ar_ready); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++; if (dm_ar_rvalid !== 1'b0 || core_ar_en !== 2'b00) begin errors++; $display("FAIL after_reset got rv=%0b en=%b exp 0/00", dm_ar_rvalid, core_ar_en); end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_resume();
    test_resume_halt_wins();
    test_ar_read();
    test_ar_done_in_issue();
    test_ar_errors();
    test_timeout_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_multihart_ctrl.md
Name: dbg_multihart_ctrl

Overview:
- Debug-side hart controller between the debug module and up to NUM_HARTS cores.
- Generalises single-core halt/resume/abstract-register handshaking to a parametrised hart count with hart-array (group) selection, aggregate status and a sequenced abstract-access FSM with error codes and timeout.
- Sits beside the core array. Each core keeps its own debug FSM and register-read mux; this block only routes, sequences and summarises.

Parameters:
- NUM_HARTS, 2, number of attached harts (1..16).
- HARTSEL_W, 4, width of hart select field; must satisfy 2**HARTSEL_W >= NUM_HARTS.
- DATA_W, 32, abstract data width.
- AR_TIMEOUT, 64, cycles to wait for core_ar_done before aborting.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- dm_hartsel  in  HARTSEL_W  primary selected hart
- dm_hasel  in  1  1 = use hart array (dm_hamask plus hartsel) for halt/resume
- dm_hamask  in  NUM_HARTS  hart array mask
- dm_haltreq  in  1  level halt request
- dm_resumereq  in  1  resume request (rising edge significant)
- dm_ar_valid  in  1  abstract command valid
- dm_ar_ready  out  1  FSM idle, command accepted this cycle when valid
- dm_ar_wr  in  1  1 = write
- dm_ar_ad  in  16  register number
- dm_ar_wdata  in  DATA_W  write data
- dm_ar_rvalid  out  1  one-cycle completion pulse
- dm_ar_rdata  out  DATA_W  read data, valid with rvalid
- dm_ar_cmderr  out  3  0 ok, 2 not supported, 4 halt/resume, 7 timeout/other; valid with rvalid
- dm_anyhalted / dm_allhalted / dm_anyrunning / dm_allrunning / dm_anyresumeack / dm_allresumeack / dm_anynonexistent  out  1 each  status over the selected set
- core_haltreq  out  NUM_HARTS  per-hart halt request
- core_resumereq  out  NUM_HARTS  per-hart resume request
- core_halted / core_running / core_resumeack  in  NUM_HARTS  per-hart status
- core_ar_en  out  NUM_HARTS  one-hot abstract enable
- core_ar_wr  out  1; core_ar_ad  out  16; core_ar_do  out  DATA_W  broadcast command fields
- core_ar_di  in  NUM_HARTS*DATA_W  per-hart read data, hart i at bits [i*DATA_W +: DATA_W]
- core_ar_done  in  NUM_HARTS  per-hart completion

Behaviour:
- Reset (async, reset_n low): all outputs 0 except dm_ar_ready=1; FSM IDLE; sticky ack bits 0; timeout counter 0.
- Selected set: sel = hamask (if dm_hasel) OR onehot(dm_hartsel); onehot is 0 if dm_hartsel >= NUM_HARTS.
- dm_anynonexistent = (dm_hartsel >= NUM_HARTS).
- Aggregate status: any* = OR over sel; all* = AND over sel. An empty sel gives all*=0.
- core_haltreq registered: core_haltreq[i] <= dm_haltreq & sel[i]. One cycle latency.
- Resume:
  - A rising edge of dm_resumereq clears the sticky ack for selected harts and arms pending[i] for selected harts that are halted.
  - core_resumereq[i] = pending[i] & ~dm_haltreq.
  - pending[i] clears when core_resumeack[i]=1; that event sets sticky ack[i].
  - A resume edge in the same cycle as dm_haltreq=1 arms nothing. Halt wins.
  - Running harts are ignored and do not set ack.
- Abstract FSM states:
  - IDLE: ready=1. On valid, latch wr/ad/wdata and target=dm_hartsel (group ignored), then check in order:
    - target nonexistent -> RESP, cmderr 7
    - target not halted -> RESP, cmderr 4
    - ad in 0x1020..0xFFFF -> RESP, cmderr 2
    - otherwise -> ISSUE
  - ISSUE: drive core_ar_en[target]=1 with latched fields. Counter reset to 0. Next WAIT.
  - WAIT: en held high.
    - core_ar_done[target] -> capture core_ar_di slice (reads) or 0 (writes), cmderr 0, RESP.
    - Else if core_halted[target] falls -> RESP, cmderr 4.
    - Else counter increments; reaching AR_TIMEOUT-1 -> RESP, cmderr 7.
  - RESP: rvalid=1 for one cycle, en low, then IDLE.
- Done arriving in ISSUE is honoured on the next WAIT cycle; it must not be lost, so latch it.
- dm_ar_rdata/cmderr hold their last values until the next RESP.
- dm_ar_valid while not IDLE is ignored; the DM retries.
- The ack-to-completion path is registered. No combinational path from core_* inputs to dm_ar_*.

Test Plan:
- NUM_HARTS=2, hartsel=1, haltreq=1 -> core_haltreq=2'b10 next cycle; after core_halted=2'b10, anyhalted=allhalted=1; hartsel=3 -> anynonexistent=1 and status all* are 0.
- hasel=1, hamask=2'b11, both halted, resumereq rising -> core_resumereq=2'b11. Ack hart0 first: anyresumeack=1, allresumeack=0. Ack hart1: allresumeack=1, core_resumereq=0.
- Resume edge with haltreq=1 -> core_resumereq stays 0, no ack.
- Read ad=0x1005 on halted hart0, core returns done after 3 cycles with di=0xDEADBEEF -> rvalid pulse, rdata=0xDEADBEEF, cmderr=0, core_ar_en high exactly ISSUE+WAIT cycles.
- Read on running hart -> cmderr=4, no core_ar_en. ad=0x2000 -> cmderr=2.
- Done never asserted -> rvalid after AR_TIMEOUT WAIT cycles, cmderr=7. Assert reset_n=0 mid-WAIT -> core_ar_en=0 and ready=1 immediately.
